// File: rtl/board_draw_pkg.sv
// Shared types and default geometry for the board draw sequencer.
package board_draw_pkg;

    localparam int GRID_N_DEF       = 4;
    localparam int TILE_PX_DEF      = 30;
    localparam int ORIGIN_X_DEF     = 20;
    localparam int ORIGIN_Y_DEF     = 0;
    localparam int DIGIT_CYCLES_DEF = 111;

    localparam logic [3:0] BLANK_TILE = 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        CLEAR,
        DRAW,
        NEXT,
        DONE
    } state_e;

endpackage

// File: rtl/board_draw_ctrl_tile_coord_counter.sv
// Row-major tile walker: tile index plus pixel origin, stepped by adders only.
module tile_coord_counter #(
    parameter int GRID_N   = 4,
    parameter int TILE_PX  = 30,
    parameter int ORIGIN_X = 20,
    parameter int ORIGIN_Y = 0,
    localparam int IDX_W   = $clog2(GRID_N * GRID_N),
    localparam int CW      = $clog2(GRID_N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [7:0]       x_base_o,
    output logic [6:0]       y_base_o,
    output logic             last_tile_o
);

    logic [IDX_W-1:0] idx_q;
    logic [CW-1:0]    row_q, col_q;
    logic [7:0]       x_q;
    logic [6:0]       y_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
            x_q   <= 8'(ORIGIN_X);
            y_q   <= 7'(ORIGIN_Y);
        end else if (clear_i) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
            x_q   <= 8'(ORIGIN_X);
            y_q   <= 7'(ORIGIN_Y);
        end else if (advance_i) begin
            idx_q <= idx_q + 1'b1;
            // Column wrap drops back to the left edge and steps one row down.
            if (col_q == CW'(GRID_N - 1)) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
                x_q   <= 8'(ORIGIN_X);
                y_q   <= y_q + 7'(TILE_PX);
            end else begin
                col_q <= col_q + 1'b1;
                x_q   <= x_q + 8'(TILE_PX);
            end
        end
    end

    assign idx_o       = idx_q;
    assign x_base_o    = x_q;
    assign y_base_o    = y_q;
    assign last_tile_o = (row_q == CW'(GRID_N - 1)) && (col_q == CW'(GRID_N - 1));

endmodule

// File: rtl/board_draw_ctrl.sv
// Board redraw sequencer: fetches each tile and runs one digit drawer pass per non-blank tile.
// Define BOARD_AUTO_REFRESH_EN to restart a pass automatically after every DONE.
module board_draw_ctrl
    import board_draw_pkg::*;
#(
    parameter int GRID_N       = GRID_N_DEF,
    parameter int TILE_PX      = TILE_PX_DEF,
    parameter int ORIGIN_X     = ORIGIN_X_DEF,
    parameter int ORIGIN_Y     = ORIGIN_Y_DEF,
    parameter int DIGIT_CYCLES = DIGIT_CYCLES_DEF,
    localparam int IDX_W       = $clog2(GRID_N * GRID_N)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [3:0]       rd_data,
    output logic [7:0]       x_base,
    output logic [6:0]       y_base,
    output logic [3:0]       digit_sel,
    output logic             drawer_enable,
    output logic             drawer_resetn,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       digit_q;
    logic             en_q, plot_q, busy_q, done_q, clr_q;
    logic             last_tile, go;

`ifdef BOARD_AUTO_REFRESH_EN
    assign go = 1'b1 | start;
`else
    assign go = start;
`endif

    tile_coord_counter #(
        .GRID_N   (GRID_N),
        .TILE_PX  (TILE_PX),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y)
    ) u_coord (
        .clk         (clk),
        .resetn      (resetn),
        .clear_i     (state_q == DONE),
        .advance_i   ((state_q == NEXT) && !last_tile),
        .idx_o       (rd_addr),
        .x_base_o    (x_base),
        .y_base_o    (y_base),
        .last_tile_o (last_tile)
    );

    // Outputs are set on the transition into their state so they track it exactly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            digit_q <= BLANK_TILE;
            en_q    <= 1'b0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            clr_q  <= 1'b0;
            case (state_q)
                IDLE: if (go) begin
                    state_q <= FETCH;
                    busy_q  <= 1'b1;
                end
                FETCH: state_q <= LATCH;
                LATCH: begin
                    digit_q <= rd_data;
                    if (rd_data == BLANK_TILE) begin
                        state_q <= NEXT;
                    end else begin
                        state_q <= CLEAR;
                        clr_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    state_q <= DRAW;
                    en_q    <= 1'b1;
                    plot_q  <= 1'b1;
                    cnt_q   <= '0;
                end
                DRAW: begin
                    if (cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
                        state_q <= NEXT;
                        en_q    <= 1'b0;
                        plot_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                NEXT: begin
                    if (last_tile) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign digit_sel     = digit_q;
    assign drawer_enable = en_q;
    assign plot          = plot_q;
    assign busy          = busy_q;
    assign done          = done_q;
    // Drawers see a clear both during system reset and for the single CLEAR cycle.
    assign drawer_resetn = resetn & ~clr_q;

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Scoreboard bench for board_draw_ctrl: expected draw windows queued per pass, popped on each plot window.
module tb_board_draw_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rd_addr;
    logic [3:0] rd_data;
    logic [7:0] x_base;
    logic [6:0] y_base;
    logic [3:0] digit_sel;
    logic       drawer_enable, drawer_resetn, plot, busy, done;

    logic [3:0] board [16];
    bit         scramble = 1'b0;

    typedef struct {
        logic [3:0] d;
        logic [7:0] x;
        logic [6:0] y;
    } exp_t;
    exp_t sb [$];

    int vectors = 0;
    int miscompares = 0;

    board_draw_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .x_base        (x_base),
        .y_base        (y_base),
        .digit_sel     (digit_sel),
        .drawer_enable (drawer_enable),
        .drawer_resetn (drawer_resetn),
        .plot          (plot),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Register file model: one cycle read latency; garbage while a digit is drawing.
    always @(posedge clk) rd_data <= scramble ? 4'($urandom_range(1, 15)) : board[rd_addr];

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_board_exp();
        for (int t = 0; t < 16; t++) begin
            if (board[t] != 4'd0) begin
                exp_t e;
                e.d = board[t];
                e.x = 8'(20 + 30 * (t % 4));
                e.y = 7'(30 * (t / 4));
                sb.push_back(e);
            end
        end
    endtask

    // One start-triggered pass; cycle 1 is the first cycle after the start-sampling edge.
    task automatic run_pass(input string nm, input int exp_done, input int ra, input int rb);
        int   cyc, ndone, nclr, nclr_exp, plen;
        logic pp, prev_drn;
        exp_t e;
        e.d = '0; e.x = '0; e.y = '0;
        push_board_exp();
        nclr_exp = sb.size();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0; ndone = 0; nclr = 0; plen = 0; pp = 1'b0; prev_drn = 1'b1;
        while (cyc < exp_done + 3) begin
            @(negedge clk);
            cyc++;
            start = (cyc == ra) || (cyc == rb);
            if (!drawer_resetn) nclr++;
            if (plot && !pp) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s unexpected_window: cyc %0d digit %0d", nm, cyc, digit_sel);
                end else begin
                    e = sb.pop_front();
                    if ({digit_sel, x_base, y_base} !== {e.d, e.x, e.y}) begin
                        miscompares++;
                        $display("FAIL %s window: got d=%0d x=%0d y=%0d expected d=%0d x=%0d y=%0d",
                                 nm, digit_sel, x_base, y_base, e.d, e.x, e.y);
                    end
                end
                vectors++;
                if (prev_drn !== 1'b0 || drawer_enable !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s clear_then_enable: prev drawer_resetn %b en %b expected 0/1",
                             nm, prev_drn, drawer_enable);
                end
                plen = 1;
            end else if (plot) begin
                plen++;
            end
            if (!plot && pp) begin
                vectors++;
                if (plen !== 111 || digit_sel !== e.d) begin
                    miscompares++;
                    $display("FAIL %s window_len: got %0d cycles d=%0d expected 111 d=%0d",
                             nm, plen, digit_sel, e.d);
                end
            end
            scramble = plot;
            if (cyc == 10) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_mid: got %b expected 1", nm, busy);
                end
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    vectors++;
                    if (cyc !== exp_done) begin
                        miscompares++;
                        $display("FAIL %s done_cycle: got %0d expected %0d", nm, cyc, exp_done);
                    end
                end
            end
            pp = plot;
            prev_drn = drawer_resetn;
        end
        start = 1'b0;
        scramble = 1'b0;
        vectors++;
        if (ndone !== 1 || sb.size() !== 0 || nclr !== nclr_exp) begin
            miscompares++;
            $display("FAIL %s pass_totals: done %0d left %0d clears %0d expected 1 0 %0d",
                     nm, ndone, sb.size(), nclr, nclr_exp);
        end
        sb.delete();
        vectors++;
        if (busy !== 1'b0 || x_base !== 8'd20 || y_base !== 7'd0 || rd_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL %s end_state: busy %b x %0d y %0d addr %0d expected 0 20 0 0",
                     nm, busy, x_base, y_base, rd_addr);
        end
    endtask

    task automatic fill_board(input int mode);
        for (int t = 0; t < 16; t++) begin
            case (mode)
                0: board[t] = 4'd0;
                1: board[t] = (t == 15) ? 4'd0 : 4'(t + 1);
                default: board[t] = (t == 5) ? 4'd9 : 4'd0;
            endcase
        end
    endtask

    task automatic test_reset();
        fill_board(0);
        resetn = 1'b0;
        #12;
        vectors++;
        if ({drawer_resetn, plot, busy, done, drawer_enable} !== 5'b0 ||
            x_base !== 8'd20 || y_base !== 7'd0 || digit_sel !== 4'd0 || rd_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_low: drn %b plot %b busy %b done %b en %b x %0d y %0d d %0d a %0d",
                     drawer_resetn, plot, busy, done, drawer_enable, x_base, y_base, digit_sel, rd_addr);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        vectors++;
        if ({drawer_resetn, plot, busy, done, drawer_enable} !== 5'b10000 ||
            x_base !== 8'd20 || y_base !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_release: drn %b plot %b busy %b done %b en %b x %0d y %0d expected 1 0 0 0 0 20 0",
                     drawer_resetn, plot, busy, done, drawer_enable, x_base, y_base);
        end
    endtask

    task automatic test_full_board();
        fill_board(1);
        run_pass("full_board", 1729, -1, -1);
    endtask

    task automatic test_tile5();
        fill_board(2);
        run_pass("tile5", 161, -1, -1);
    endtask

    task automatic test_all_blank();
        int nplot;
        fill_board(0);
        run_pass("all_blank", 49, -1, -1);
    endtask

    task automatic test_start_ignored();
        fill_board(1);
        run_pass("start_ignored", 1729, 10, 500);
    endtask

    task automatic test_reset_mid_draw();
        int n;
        fill_board(1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(plot && digit_sel == 4'd4) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 1000) begin
            miscompares++;
            $display("FAIL reset_mid_draw_reach: tile 3 draw not seen within %0d cycles", n);
        end
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        vectors++;
        if ({plot, busy, drawer_enable, drawer_resetn} !== 4'b0 || x_base !== 8'd20 || y_base !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_mid_draw: plot %b busy %b en %b drn %b x %0d y %0d expected 0 0 0 0 20 0",
                     plot, busy, drawer_enable, drawer_resetn, x_base, y_base);
        end
        @(negedge clk);
        resetn = 1'b1;
        run_pass("redraw_after_reset", 1729, -1, -1);
    endtask

    // Start held (or auto refresh): passes separated by exactly one idle cycle.
    task automatic test_back_to_back(input string nm, input bit hold);
        int cyc, ndone;
        int dc [3];
        fill_board(0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0; ndone = 0;
        while (cyc < 160) begin
            @(negedge clk);
            cyc++;
            start = hold && (cyc < 100);
            if (done) begin
                if (ndone < 3) dc[ndone] = cyc;
                ndone++;
            end
            if (cyc == 50) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s idle_gap: busy %b expected 0", nm, busy);
                end
            end
            if (plot) begin
                vectors++;
                miscompares++;
                $display("FAIL %s plot_on_blank: got 1 expected 0", nm);
            end
        end
        start = 1'b0;
        vectors++;
`ifdef BOARD_AUTO_REFRESH_EN
        if (ndone < 3 || dc[0] != 49 || dc[1] != 99 || dc[2] != 149) begin
            miscompares++;
            $display("FAIL %s done_train: got %0d pulses first %0d %0d %0d expected 49 99 149",
                     nm, ndone, dc[0], dc[1], dc[2]);
        end
`else
        if (ndone != 2 || dc[0] != 49 || dc[1] != 99 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pair: got %0d pulses at %0d %0d busy %b expected 2 at 49 99 busy 0",
                     nm, ndone, dc[0], dc[1], busy);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            board[i] = 4'd0;
        end
        test_reset();
`ifdef BOARD_AUTO_REFRESH_EN
        test_back_to_back("auto_refresh", 1'b0);
`else
        test_full_board();
        test_tile5();
        test_all_blank();
        test_start_ignored();
        test_reset_mid_draw();
        test_back_to_back("start_held", 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
